// File: rtl/fpga_cfg_loader.sv
// Serial-to-parallel configuration loader for the 4-input LUT array.
// Optional word parity checking is compiled in with `define FPGA_CFG_PARITY_EN.
module fpga_cfg_loader #(
    parameter int NUM_LUTS = 8,
    parameter int LUT_BITS = 16
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                start_i,
    input  logic                cfg_valid_i,
    input  logic                cfg_bit_i,
    output logic                cfg_ready_o,
    output logic [LUT_BITS-1:0] lut_data_o,
    output logic [NUM_LUTS-1:0] lut_we_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [2:0]          dbg_state_o
);

    localparam int ADDR_W = $clog2(NUM_LUTS);
`ifdef FPGA_CFG_PARITY_EN
    localparam int WORD_BITS = LUT_BITS + 1;
`else
    localparam int WORD_BITS = LUT_BITS;
`endif
    localparam int CNT_W = $clog2(WORD_BITS + 1);
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(WORD_BITS - 1);
    localparam logic [ADDR_W-1:0]   LAST_IDX = ADDR_W'(NUM_LUTS - 1);
    localparam logic [NUM_LUTS-1:0] WE_ONE   = {{(NUM_LUTS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    // Handshake: a bit transfers on a rising edge where cfg_valid_i && cfg_ready_o;
    // cfg_ready_o is a function of state only, so the source may stall freely.
    state_e              state_q, state_d;
    logic [LUT_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [LUT_BITS-1:0] lut_data_q, lut_data_d;
    logic [NUM_LUTS-1:0] lut_we_q, lut_we_d;
    logic [LUT_BITS-1:0] shift_in;
    logic                accept;

    assign cfg_ready_o = (state_q == S_SHIFT);
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign shift_in    = {cfg_bit_i, shift_q[LUT_BITS-1:1]};
    assign busy_o      = (state_q == S_SHIFT) || (state_q == S_WRITE);
    assign done_o      = (state_q == S_DONE);
    assign lut_data_o  = lut_data_q;
    assign lut_we_o    = lut_we_q;
    assign dbg_state_o = state_q;

`ifdef FPGA_CFG_PARITY_EN
    logic par_q, par_d;
    assign err_o = (state_q == S_ERR);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) par_q <= 1'b0;
        else           par_q <= par_d;
    end
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            index_q    <= '0;
            lut_data_q <= '0;
            lut_we_q   <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            index_q    <= index_d;
            lut_data_q <= lut_data_d;
            lut_we_q   <= lut_we_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        index_d    = index_q;
        lut_data_d = lut_data_q;
        lut_we_d   = '0;
`ifdef FPGA_CFG_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d  = S_SHIFT;
                    index_d  = '0;
                    bitcnt_d = '0;
`ifdef FPGA_CFG_PARITY_EN
                    par_d    = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    bitcnt_d = bitcnt_q + CNT_W'(1);
`ifdef FPGA_CFG_PARITY_EN
                    // The trailing parity bit is checked but never enters the word.
                    par_d = par_q ^ cfg_bit_i;
                    if (bitcnt_q < CNT_W'(LUT_BITS)) shift_d = shift_in;
                    if (bitcnt_q == LAST_BIT) begin
                        if (par_q ^ cfg_bit_i) begin
                            state_d = S_ERR;
                        end else begin
                            state_d    = S_WRITE;
                            lut_data_d = shift_q;
                            lut_we_d   = WE_ONE << index_q;
                        end
                    end
`else
                    shift_d = shift_in;
                    if (bitcnt_q == LAST_BIT) begin
                        state_d    = S_WRITE;
                        lut_data_d = shift_in;
                        lut_we_d   = WE_ONE << index_q;
                    end
`endif
                end
            end
            S_WRITE: begin
                // Stop at the last LUT rather than letting the index wrap.
                if (index_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_SHIFT;
                    index_d  = index_q + ADDR_W'(1);
                    bitcnt_d = '0;
`ifdef FPGA_CFG_PARITY_EN
                    par_d    = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed self-checking bench for fpga_cfg_loader (8 LUTs, either parity build).
module tb_fpga_cfg_loader;

    localparam int NL = 8;
`ifdef FPGA_CFG_PARITY_EN
    localparam int WB = 17;
`else
    localparam int WB = 16;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_i;
    logic          cfg_valid;
    logic          cfg_bit;
    logic          cfg_ready;
    logic [15:0]   lut_data;
    logic [NL-1:0] lut_we;
    logic          busy, done, err;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [NL+15:0] exp_q[$];
    logic [NL-1:0]  prev_we = '0;

    always #5 clk = ~clk;

    fpga_cfg_loader #(.NUM_LUTS(NL), .LUT_BITS(16)) dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start_i),
        .cfg_valid_i(cfg_valid), .cfg_bit_i(cfg_bit), .cfg_ready_o(cfg_ready),
        .lut_data_o(lut_data), .lut_we_o(lut_we), .busy_o(busy),
        .done_o(done), .err_o(err), .dbg_state_o(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Strobe scoreboard: every write pulse must match the head of exp_q.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
`ifndef FPGA_CFG_PARITY_EN
            chk("err_low", {31'd0, err}, 32'd0);
`endif
            if (lut_we !== '0) begin
                chk("we_single_cycle", {24'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", {24'd0, lut_we}, 32'd0);
                end else begin
                    logic [NL+15:0] e;
                    e = exp_q.pop_front();
                    chk("lut_we", {24'd0, lut_we}, {24'd0, e[NL+15:16]});
                    chk("lut_data", {16'd0, lut_data}, {16'd0, e[15:0]});
                end
            end
            prev_we = lut_we;
        end else begin
            prev_we = '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_ready", {31'd0, cfg_ready}, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps, input bit pulse5,
                             input bit bad_par);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < WB && guard < 400) begin
            cfg_bit   = (i < 16) ? w[i] : ((^w) ^ bad_par);
            cfg_valid = gaps ? ($urandom_range(0, 99) >= 50) : 1'b1;
            start_i   = (pulse5 && i == 5);
            acc       = cfg_valid && cfg_ready;
            step();
            start_i = 1'b0;
            if (acc) i++;
            guard++;
        end
        cfg_valid = 1'b0;
        if (guard >= 400) chk("bit_timeout", i, WB);
    endtask

    task automatic send_frame(input bit gaps, input bit pulse5);
        logic [NL-1:0] we_e;
        logic [15:0]   w;
        for (int k = 0; k < NL; k++) begin
            we_e = '0;
            we_e[k] = 1'b1;
            w = 16'hA5A0 + 16'(k);
            exp_q.push_back({we_e, w});
            send_word(w, gaps, pulse5 && (k == 0), 1'b0);
            chk("write_busy", {31'd0, busy}, 32'd1);
        end
        step();
        chk("done_set", {31'd0, done}, 32'd1);
        chk("done_not_busy", {31'd0, busy}, 32'd0);
        chk("done_not_ready", {31'd0, cfg_ready}, 32'd0);
        chk("all_strobes_seen", exp_q.size(), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start_i = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_we", {24'd0, lut_we}, 32'd0);
        chk("rst_data", {16'd0, lut_data}, 32'd0);

        // Reset mid-word after 7 accepted bits: no partial write, clean restart.
        do_start();
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1; cfg_bit = i[0];
            step();
        end
        cfg_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("midrst_we", {24'd0, lut_we}, 32'd0);
        chk("midrst_data", {16'd0, lut_data}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("midrst_idle", {29'd0, dbg_state}, 32'd0);
        do_start();
        send_frame(1'b0, 1'b0);

        // Extra bit offered in DONE must not be consumed.
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("done_extra_ready", {31'd0, cfg_ready}, 32'd0);
            step();
            chk("done_extra_state", {29'd0, dbg_state}, 32'd3);
        end
        cfg_valid = 1'b0;
        chk("done_held", {31'd0, done}, 32'd1);

        // Same stream with random valid gaps.
        do_start();
        chk("restart_done_clr", {31'd0, done}, 32'd0);
        send_frame(1'b1, 1'b0);

        // start_i pulsed at bit 5 of word 0 is ignored.
        do_start();
        send_frame(1'b0, 1'b1);

`ifdef FPGA_CFG_PARITY_EN
        // Word 0x0001 with parity bit 0 is a mismatch: ERR, no strobe.
        do_start();
        send_word(16'h0001, 1'b0, 1'b0, 1'b1);
        chk("par_err", {31'd0, err}, 32'd1);
        chk("par_ready", {31'd0, cfg_ready}, 32'd0);
        chk("par_busy", {31'd0, busy}, 32'd0);
        step();
        chk("par_err_sticky", {31'd0, err}, 32'd1);
        do_start();
        chk("par_err_clr", {31'd0, err}, 32'd0);
        send_frame(1'b0, 1'b0);
`endif

        repeat (3) step();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
